// File: rtl/tx_sched.sv
// tx_sched: two-channel threshold/round-robin transmit scheduler with grant watchdog.
// Optional anti-starvation aging is compiled in with `define TX_SCHED_AGING_EN.
module tx_sched #(
  parameter int CNT_W     = 8,
  parameter int THRESH    = 4,
  parameter int MAX_BURST = 16,
  parameter int MAX_WAIT  = 64,
  parameter int GRANT_TO  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] f1_bf_cnt,
  input  logic [CNT_W-1:0] f2_bf_cnt,
  input  logic             next,
  output logic [1:0]       rdy_cnl,
  output logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             to_err
);

  localparam int WD_W  = $clog2(GRANT_TO + 1);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MAXB    = CNT_W'(MAX_BURST);
  localparam logic [WD_W-1:0]  WD_TOP  = WD_W'(GRANT_TO - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    GRANT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rdy_nxt;
  logic [CNT_W-1:0] len_nxt;
  logic             err_nxt;
  logic [WD_W-1:0]  wd;
  logic [WD_W-1:0]  wd_nxt;
  logic             last_ch;
  logic             last_nxt;
  logic [1:0]       elig;
  logic [1:0]       pick;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] len2;

  assign len1 = (f1_bf_cnt < MAXB) ? f1_bf_cnt : MAXB;
  assign len2 = (f2_bf_cnt < MAXB) ? f2_bf_cnt : MAXB;

`ifdef TX_SCHED_AGING_EN
  logic [AGE_W-1:0] age1;
  logic [AGE_W-1:0] age2;

  // A channel's age restarts while it is empty or holds/receives the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      age1 <= '0;
      age2 <= '0;
    end else begin
      if (f1_bf_cnt == '0 || rdy_cnl[0] || pick[0])
        age1 <= '0;
      else if (age1 < AGE_MAX)
        age1 <= age1 + 1'b1;
      if (f2_bf_cnt == '0 || rdy_cnl[1] || pick[1])
        age2 <= '0;
      else if (age2 < AGE_MAX)
        age2 <= age2 + 1'b1;
    end
  end

  assign elig[0] = (f1_bf_cnt >= THR) ||
                   (f1_bf_cnt != '0 && age1 >= AGE_MAX);
  assign elig[1] = (f2_bf_cnt >= THR) ||
                   (f2_bf_cnt != '0 && age2 >= AGE_MAX);
`else
  logic unused_age;
  assign unused_age = ^AGE_MAX;
  assign elig[0] = (f1_bf_cnt >= THR);
  assign elig[1] = (f2_bf_cnt >= THR);
`endif

  // last_ch = 1 means channel 2 was served last, so channel 1 wins a tie.
  always_comb begin
    pick = '0;
    if (state == ARB && start) begin
      unique case (elig)
        2'b01:   pick = 2'b01;
        2'b10:   pick = 2'b10;
        2'b11:   pick = last_ch ? 2'b01 : 2'b10;
        default: pick = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy_nxt   = rdy_cnl;
    len_nxt   = burst_len;
    err_nxt   = 1'b0;
    wd_nxt    = wd;
    last_nxt  = last_ch;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = ARB;
      end
      ARB: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (pick != 2'b00) begin
          rdy_nxt   = pick;
          len_nxt   = pick[0] ? len1 : len2;
          wd_nxt    = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (next) begin
          rdy_nxt   = '0;
          len_nxt   = '0;
          last_nxt  = rdy_cnl[1];
          state_nxt = start ? ARB : IDLE;
        end else if (wd == WD_TOP) begin
          rdy_nxt   = '0;
          len_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = start ? ARB : IDLE;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        rdy_nxt   = '0;
        len_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy_cnl   <= '0;
      burst_len <= '0;
      to_err    <= 1'b0;
      wd        <= '0;
      last_ch   <= 1'b1;
    end else begin
      state     <= state_nxt;
      rdy_cnl   <= rdy_nxt;
      burst_len <= len_nxt;
      to_err    <= err_nxt;
      wd        <= wd_nxt;
      last_ch   <= last_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: directed scenarios plus randomized traffic checked every
// cycle against a behavioural scheduler model.
module tb_tx_sched;

  localparam int CNT_W     = 8;
  localparam int THRESH    = 4;
  localparam int MAX_BURST = 16;
  localparam int MAX_WAIT  = 64;
  localparam int GRANT_TO  = 1024;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] f1;
  logic [CNT_W-1:0] f2;
  logic             next;
  logic [1:0]       rdy_cnl;
  logic [CNT_W-1:0] burst_len;
  logic             busy;
  logic             to_err;

  tx_sched #(
    .CNT_W(CNT_W), .THRESH(THRESH), .MAX_BURST(MAX_BURST),
    .MAX_WAIT(MAX_WAIT), .GRANT_TO(GRANT_TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .f1_bf_cnt(f1), .f2_bf_cnt(f2), .next(next),
    .rdy_cnl(rdy_cnl), .burst_len(burst_len),
    .busy(busy), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk = 0;

  // model: phase 0 = disabled, 1 = looking for work, 2 = burst open
  int m_ph = 0;
  int m_ch = 0;
  int m_len = 0;
  int m_err = 0;
  int m_last = 2;
  int m_wd = 0;
  int m_age1 = 0;
  int m_age2 = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age_upd(int a, int c, bit hold);
    if (c == 0 || hold) return 0;
    return (a + 1 > MAX_WAIT) ? MAX_WAIT : a + 1;
  endfunction

  task automatic model_step();
    bit e1;
    bit e2;
    int p;
    int c1;
    int c2;
    int c;
    c1 = int'(f1);
    c2 = int'(f2);
    if (rst) begin
      m_ph = 0; m_ch = 0; m_len = 0; m_err = 0;
      m_last = 2; m_wd = 0; m_age1 = 0; m_age2 = 0;
      return;
    end
`ifdef TX_SCHED_AGING_EN
    e1 = c1 >= THRESH || (c1 != 0 && m_age1 >= MAX_WAIT);
    e2 = c2 >= THRESH || (c2 != 0 && m_age2 >= MAX_WAIT);
`else
    e1 = c1 >= THRESH;
    e2 = c2 >= THRESH;
`endif
    p = 0;
    if (m_ph == 1 && start) begin
      if (e1 && e2) p = (m_last == 1) ? 2 : 1;
      else if (e1) p = 1;
      else if (e2) p = 2;
    end
    m_age1 = age_upd(m_age1, c1, m_ch == 1 || p == 1);
    m_age2 = age_upd(m_age2, c2, m_ch == 2 || p == 2);
    m_err = 0;
    case (m_ph)
      0: if (start) m_ph = 1;
      1: begin
        if (!start) m_ph = 0;
        else if (p != 0) begin
          c = (p == 1) ? c1 : c2;
          m_ch = p;
          m_len = (c < MAX_BURST) ? c : MAX_BURST;
          m_wd = 0;
          m_ph = 2;
        end
      end
      default: begin
        if (next) begin
          m_last = m_ch; m_ch = 0; m_len = 0;
          m_ph = start ? 1 : 0;
        end else if (m_wd == GRANT_TO - 1) begin
          m_ch = 0; m_len = 0; m_err = 1;
          m_ph = start ? 1 : 0;
        end else begin
          m_wd++;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("rdy_cnl", 32'(rdy_cnl), 32'(m_ch));
      check("burst_len", 32'(burst_len), 32'(m_len));
      check("busy", 32'(busy), 32'(m_ph != 0));
      check("to_err", 32'(to_err), 32'(m_err));
    end
  end

  task automatic cyc(input bit r, input bit s, input int a, input int b,
                     input bit n);
    @(negedge clk);
    rst = r; start = s; next = n;
    f1 = CNT_W'(a); f2 = CNT_W'(b);
    @(posedge clk);
    model_step();
    #1;
  endtask

  int ng;
  int since;
  logic [1:0] exp_ch;
  int r1;
  int r2;

  initial begin
    rst = 1; start = 0; next = 0; f1 = 0; f2 = 0;
    cyc(1, 0, 0, 0, 0);
    chk = 1;
    cyc(1, 0, 0, 0, 0);
    check("reset_rdy", 32'(rdy_cnl), 0);
    check("reset_len", 32'(burst_len), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_err", 32'(to_err), 0);

    // first grant two cycles after start
    cyc(0, 1, 5, 0, 0);
    check("arb_busy", 32'(busy), 1);
    check("arb_rdy", 32'(rdy_cnl), 0);
    cyc(0, 1, 5, 0, 0);
    check("first_rdy", 32'(rdy_cnl), 32'b01);
    check("first_len", 32'(burst_len), 5);
    cyc(0, 1, 5, 0, 1);
    check("next_clr", 32'(rdy_cnl), 0);

    // round robin: channel 1 served last, so channel 2 wins next
    ng = 0; since = -1; exp_ch = 2'b10;
    for (int k = 0; k < 200 && ng < 4; k++) begin
      cyc(0, 1, 20, 20, since == 3);
      if (since == 3) since = -1;
      else if (since >= 0) since++;
      else if (rdy_cnl != 2'b00) begin
        check("rr_ch", 32'(rdy_cnl), 32'(exp_ch));
        check("rr_len", 32'(burst_len), 16);
        exp_ch = ~exp_ch;
        ng++;
        since = 0;
      end
    end
    check("rr_grants", ng, 4);

    // watchdog on channel 2
    cyc(0, 1, 0, 10, 1);
    ng = 0;
    for (int k = 0; k < 10 && ng == 0; k++) begin
      cyc(0, 1, 0, 10, 0);
      if (rdy_cnl != 2'b00) ng = 1;
    end
    check("to_grant", 32'(rdy_cnl), 32'b10);
    for (int k = 0; k < GRANT_TO - 1; k++) cyc(0, 1, 0, 10, 0);
    check("to_hold", 32'(rdy_cnl), 32'b10);
    check("to_early", 32'(to_err), 0);
    cyc(0, 1, 0, 10, 0);
    check("to_err", 32'(to_err), 1);
    check("to_rdy", 32'(rdy_cnl), 0);
    cyc(0, 1, 0, 10, 0);
    check("to_pulse", 32'(to_err), 0);
    check("to_regrant", 32'(rdy_cnl), 32'b10);
    cyc(0, 1, 0, 10, 1);

    // sub-threshold channel: aging only
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) cyc(0, 1, 2, 0, 0);
    check("age_wait", 32'(rdy_cnl), 0);
    cyc(0, 1, 2, 0, 0);
`ifdef TX_SCHED_AGING_EN
    check("age_rdy", 32'(rdy_cnl), 32'b01);
    check("age_len", 32'(burst_len), 2);
    cyc(0, 1, 2, 0, 1);
`else
    for (int k = 0; k < 100; k++) cyc(0, 1, 2, 0, 0);
    check("noage_rdy", 32'(rdy_cnl), 0);
`endif

    // drop start mid-burst, then reset mid-burst
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 8, 0, 0);
    cyc(0, 1, 8, 0, 0);
    check("drop_grant", 32'(rdy_cnl), 32'b01);
    check("drop_len", 32'(burst_len), 8);
    for (int k = 0; k < 5; k++) cyc(0, 0, 8, 0, 0);
    check("drop_hold", 32'(rdy_cnl), 32'b01);
    check("drop_busy", 32'(busy), 1);
    cyc(0, 0, 8, 0, 1);
    check("drop_rdy", 32'(rdy_cnl), 0);
    check("drop_idle", 32'(busy), 0);
    cyc(0, 1, 0, 30, 0);
    cyc(0, 1, 0, 30, 0);
    check("rst_pre", 32'(burst_len), 16);
    cyc(1, 1, 0, 30, 0);
    check("rst_rdy", 32'(rdy_cnl), 0);
    check("rst_len", 32'(burst_len), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(to_err), 0);

    // randomized traffic
    r1 = 0; r2 = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0)
        r1 = ($urandom_range(0, 3) == 0) ? 0 :
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) :
             $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0)
        r2 = ($urandom_range(0, 3) == 0) ? 0 :
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) :
             $urandom_range(0, 40);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
          r1, r2, $urandom_range(0, 5) == 0);
    end

    @(negedge clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
